// File: rtl/lpc_frame_control.sv
`default_nettype none
// ============================================================================
// Module   : lpc_frame_control
// Purpose  : Frame sequencer that loads samples into memory, hands the memory
//            to the encoder, then waits for the encoder to finish. Define
//            LPC_FRAME_WDOG_EN to build in the encoder watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module lpc_frame_control #(
  parameter int FRAME_LEN   = 160,
  parameter int ADDR_W      = 8,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_go,
  input  logic              cont,
  input  logic              abort,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_sel,
  output logic              enc_start,
  input  logic              enc_done,
  output logic              enc_abort,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              wdog_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              abort_hit;
  logic              wdog_trip;

  assign abort_hit = abort && (state_q != ST_IDLE);

`ifdef LPC_FRAME_WDOG_EN
  localparam int                WDOG_W    = $clog2(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;

  // A same-cycle enc_done beats the watchdog expiry.
  assign wdog_trip = (state_q == ST_RUN) && (wdog_cnt_q == WDOG_LAST) && !enc_done;

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    wdog_err_d = wdog_err_q;
    if (state_q == ST_START) begin
      wdog_cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
    end
    if (state_q == ST_IDLE && frame_go) begin
      wdog_err_d = 1'b0;
    end else if (wdog_trip) begin
      wdog_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_trip = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_count_d = frame_count_q;
    if (abort_hit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_go) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end
        end
        ST_LOAD: begin
          // The final sample holds the counter so the address never wraps.
          if (load_valid) begin
            if (cnt_q == LAST_ADDR) begin
              state_d = ST_START;
            end else begin
              cnt_d = cnt_q + ADDR_W'(1);
            end
          end
        end
        ST_START: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (enc_done) begin
            state_d = ST_DONE;
          end else if (wdog_trip) begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          frame_count_d = frame_count_q + 16'd1;
          if (cont) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    load_ready = 1'b0;
    mem_sel    = 1'b0;
    enc_start  = 1'b0;
    enc_abort  = 1'b0;
    frame_done = 1'b0;
    if (!reset) begin
      load_ready = (state_q == ST_LOAD) && !abort;
      mem_sel    = (state_q == ST_START) || (state_q == ST_RUN);
      enc_start  = (state_q == ST_START) && !abort;
      enc_abort  = abort_hit || wdog_trip;
      frame_done = (state_q == ST_DONE) && !abort;
    end
  end

  assign mem_we      = load_valid && load_ready;
  assign mem_waddr   = cnt_q;
  assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lpc_frame_control.sv
`default_nettype none
// Bench for lpc_frame_control: transaction-level expected events are queued by
// the stimulus and popped by an independent monitor whenever the DUT emits one.
module tb_lpc_frame_control;

  localparam int FLEN = 4;
  localparam int AW   = 8;
  localparam int WDOG = 8;

  localparam int K_WRITE = 0;
  localparam int K_START = 1;
  localparam int K_DONE  = 2;
  localparam int K_ABORT = 3;

  localparam int M_NORMAL     = 0;
  localparam int M_ABORT_LOAD = 1;
  localparam int M_ABORT_RUN  = 2;
  localparam int M_ABORT_DONE = 3;
  localparam int M_WDOG       = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_go = 1'b0;
  logic          cont = 1'b0;
  logic          abort = 1'b0;
  logic          load_valid = 1'b0;
  logic          enc_done = 1'b0;
  logic          load_ready, mem_we, mem_sel, enc_start, enc_abort, frame_done, wdog_err;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   frame_count;

  int checks   = 0;
  int failures = 0;
  int model_count = 0;

  typedef struct {
    int kind;
    int val;
  } ev_t;
  ev_t exp_q[$];

  lpc_frame_control #(
    .FRAME_LEN  (FLEN),
    .ADDR_W     (AW),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_go   (frame_go),
    .cont       (cont),
    .abort      (abort),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_sel    (mem_sel),
    .enc_start  (enc_start),
    .enc_done   (enc_done),
    .enc_abort  (enc_abort),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .wdog_err   (wdog_err)
  );

  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      K_WRITE: return "write";
      K_START: return "enc_start";
      K_DONE:  return "frame_done";
      default: return "enc_abort";
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  task automatic pop_cmp(input int k, input int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got %s/%0d expected nothing", kname(k), v);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (e.kind != k || e.val != v) begin
        failures++;
        $display("FAIL event_order: got %s/%0d expected %s/%0d", kname(k), v, kname(e.kind), e.val);
      end
    end
  endtask

  // Monitor: every observed output event must match the head of the queue.
  always @(negedge clk) begin
    if (mem_we)     pop_cmp(K_WRITE, int'(mem_waddr));
    if (enc_start)  pop_cmp(K_START, 0);
    if (frame_done) pop_cmp(K_DONE, int'(frame_count));
    if (enc_abort)  pop_cmp(K_ABORT, 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    frame_go   = 1'b0;
    abort      = 1'b0;
    load_valid = 1'b0;
    enc_done   = 1'b0;
    cont       = 1'b0;
  endtask

  function automatic bit ends_in_load(input int mode, input bit cont_after);
`ifdef LPC_FRAME_WDOG_EN
    return cont_after && (mode == M_NORMAL);
`else
    return cont_after && (mode == M_NORMAL || mode == M_WDOG);
`endif
  endfunction

  task automatic run_frame(input int mode, input int lv_mode, input int run_delay,
                           input bit cont_after, input bit from_idle);
    int acc = 0;
    int cyc = 0;
    if (from_idle) begin
      frame_go = 1'b1;
      abort    = 1'($urandom_range(0, 1));
      enc_done = 1'($urandom_range(0, 1));
      tick();
      clear_inputs();
      #1;
      check("wdog_err_cleared_on_go", wdog_err, 0);
    end
    #1;
    check("load_ready_in_load", load_ready, 1);
    check("mem_sel_in_load", mem_sel, 0);
    while (acc < FLEN) begin
      case (lv_mode)
        0:       load_valid = 1'($urandom_range(0, 1));
        1:       load_valid = 1'b1;
        default: load_valid = (cyc % 2 == 0);
      endcase
      enc_done = ($urandom_range(0, 3) == 0);
      frame_go = 1'($urandom_range(0, 1));
      cont     = 1'($urandom_range(0, 1));
      if (mode == M_ABORT_LOAD && acc == FLEN / 2) begin
        abort = 1'b1;
        push(K_ABORT, 0);
        tick();
        clear_inputs();
        #1;
        check("idle_after_load_abort", load_ready, 0);
        return;
      end
      if (load_valid) begin
        push(K_WRITE, acc);
        acc++;
      end
      if (acc == FLEN) push(K_START, 0);
      cyc++;
      tick();
    end
    load_valid = 1'b0;
    enc_done   = 1'($urandom_range(0, 1));
    frame_go   = 1'($urandom_range(0, 1));
    #1;
    check("mem_sel_in_start", mem_sel, 1);
    tick();
    enc_done = 1'b0;
    if (mode == M_WDOG) begin
`ifdef LPC_FRAME_WDOG_EN
      frame_go = 1'b0;
      repeat (WDOG - 1) tick();
      push(K_ABORT, 0);
      tick();
      #1;
      check("wdog_err_set", wdog_err, 1);
      check("mem_sel_after_wdog", mem_sel, 0);
      clear_inputs();
      return;
`else
      repeat (3 * WDOG) begin
        frame_go = 1'($urandom_range(0, 1));
        tick();
      end
      #1;
      check("still_in_run", mem_sel, 1);
      check("wdog_err_tied_low", wdog_err, 0);
`endif
    end else begin
      for (int k = 0; k < run_delay; k++) begin
        frame_go = 1'($urandom_range(0, 1));
        tick();
      end
    end
    if (mode == M_ABORT_RUN) begin
      abort    = 1'b1;
      enc_done = 1'b1;
      push(K_ABORT, 0);
      tick();
      clear_inputs();
      #1;
      check("count_after_run_abort", frame_count, model_count);
      check("mem_sel_after_run_abort", mem_sel, 0);
      return;
    end
    enc_done = 1'b1;
    cont     = cont_after;
    frame_go = 1'($urandom_range(0, 1));
    tick();
    enc_done = 1'($urandom_range(0, 1));
    #1;
    check("mem_sel_in_done", mem_sel, 0);
    if (mode == M_ABORT_DONE) begin
      abort = 1'b1;
      push(K_ABORT, 0);
      tick();
      clear_inputs();
      #1;
      check("count_after_done_abort", frame_count, model_count);
      return;
    end
    push(K_DONE, model_count);
    model_count = (model_count + 1) & 16'hFFFF;
    tick();
    clear_inputs();
    #1;
    check("frame_count", frame_count, model_count);
    check("next_state_load", load_ready, int'(cont_after));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit in_load = 1'b0;
    reset = 1'b1;
    abort = 1'b1; frame_go = 1'b1; load_valid = 1'b1; enc_done = 1'b1; cont = 1'b1;
    repeat (3) tick();
    check("reset_load_ready", load_ready, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_mem_sel", mem_sel, 0);
    check("reset_enc_abort", enc_abort, 0);
    reset = 1'b0;
    clear_inputs();
    tick();
    check("reset_frame_count", frame_count, 0);
    check("reset_wdog_err", wdog_err, 0);
    check("idle_load_ready", load_ready, 0);

    run_frame(M_NORMAL, 1, 4, 1'b0, 1'b1);
    run_frame(M_NORMAL, 2, 2, 1'b0, 1'b1);
    run_frame(M_NORMAL, 0, 3, 1'b1, 1'b1);
    run_frame(M_NORMAL, 0, 1, 1'b1, 1'b0);
    run_frame(M_NORMAL, 0, 0, 1'b0, 1'b0);
    run_frame(M_ABORT_RUN, 0, 2, 1'b0, 1'b1);
    run_frame(M_WDOG, 0, 0, 1'b0, 1'b1);
    run_frame(M_NORMAL, 0, WDOG - 1, 1'b0, 1'b1);
    run_frame(M_ABORT_LOAD, 1, 0, 1'b0, 1'b1);
    run_frame(M_ABORT_DONE, 0, 1, 1'b1, 1'b1);

    // Reset mid-load: no abort pulse, no writes, counters cleared.
    frame_go = 1'b1;
    tick();
    frame_go   = 1'b0;
    load_valid = 1'b1;
    push(K_WRITE, 0);
    tick();
    push(K_WRITE, 1);
    tick();
    reset = 1'b1;
    abort = 1'b1;
    #1;
    check("reset_midframe_mem_we", mem_we, 0);
    check("reset_midframe_enc_abort", enc_abort, 0);
    tick();
    tick();
    reset = 1'b0;
    clear_inputs();
    tick();
    model_count = 0;
    check("reset_midframe_count", frame_count, 0);
    check("reset_midframe_queue", exp_q.size(), 0);

    for (int i = 0; i < 30; i++) begin
      int  mode;
      int  dly;
      bit  ca;
      case ($urandom_range(0, 9))
        0:       mode = M_ABORT_LOAD;
        1:       mode = M_ABORT_RUN;
        2:       mode = M_ABORT_DONE;
        3:       mode = M_WDOG;
        default: mode = M_NORMAL;
      endcase
      dly = (mode == M_WDOG) ? 0 : int'($urandom_range(0, WDOG - 1));
      ca  = 1'($urandom_range(0, 1));
      if (!in_load) begin
        repeat ($urandom_range(0, 3)) begin
          abort      = 1'($urandom_range(0, 1));
          load_valid = 1'($urandom_range(0, 1));
          enc_done   = 1'($urandom_range(0, 1));
          tick();
        end
        clear_inputs();
      end
      run_frame(mode, int'($urandom_range(0, 2)), dly, ca, !in_load);
      in_load = ends_in_load(mode, ca);
    end
    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
